// File: rtl/sdram_arbiter_if.sv
// Request/response bundle between the two client ports, the arbiter and the SDRAM controller.
// slave = arbiter view; master = clients plus controller (drives requests and dout).
interface sdram_arbiter_if;
   logic        pause;
   logic        a_req;
   logic [23:0] a_addr;
   logic [15:0] a_rdata;
   logic        a_ack;
   logic        b_req;
   logic        b_we;
   logic [24:0] b_addr;
   logic [7:0]  b_wdata;
   logic [7:0]  b_rdata;
   logic        b_ack;
   logic        sd_sync;
   logic        sd_oe;
   logic        sd_we;
   logic [23:0] sd_addr;
   logic [15:0] sd_din;
   logic [1:0]  sd_ds;
   logic        sd_autorefresh;
   logic        sd_refresh;
   logic [15:0] sd_dout;

   modport slave (
      input  pause, a_req, a_addr, b_req, b_we, b_addr, b_wdata, sd_dout,
      output a_rdata, a_ack, b_rdata, b_ack, sd_sync, sd_oe, sd_we,
             sd_addr, sd_din, sd_ds, sd_autorefresh, sd_refresh
   );

   modport master (
      output pause, a_req, a_addr, b_req, b_we, b_addr, b_wdata, sd_dout,
      input  a_rdata, a_ack, b_rdata, b_ack, sd_sync, sd_oe, sd_we,
             sd_addr, sd_din, sd_ds, sd_autorefresh, sd_refresh
   );
endinterface

// File: rtl/sdram_arbiter.sv
// One grant per 8-clock SDRAM frame, A over B; ack 8 clocks after the grant edge, requests wait level-held.
// Define SDRAM_ARB_STARVE_EN to force a pending B grant after STARVE_MAX consecutive A grants.
module sdram_arbiter #(
   parameter int RD_SLOT    = 7,
   parameter int STARVE_MAX = 4
) (
   input logic            clk,
   input logic            reset_n,
   sdram_arbiter_if.slave bus
);
   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] BUSY_A = 2'd1;
   localparam logic [1:0] BUSY_B = 2'd2;
   localparam logic [2:0] RD_PT  = RD_SLOT[2:0];

   logic [2:0] slot;
   logic [1:0] state;
   logic       slot_end;
   logic       grant_a;
   logic       grant_b;
   logic       force_b;

   assign slot_end           = (slot == 3'd7);
   assign bus.sd_sync        = ~slot[2];
   assign bus.sd_autorefresh = ~bus.pause;
   assign bus.sd_refresh     = bus.pause;

`ifdef SDRAM_ARB_STARVE_EN
   localparam int CW = $clog2(STARVE_MAX + 1);
   logic [CW-1:0] starve_cnt;

   assign force_b = bus.b_req && (starve_cnt == CW'(STARVE_MAX));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         starve_cnt <= '0;
      end else if (!bus.b_req || grant_b) begin
         starve_cnt <= '0;
      end else if (grant_a) begin
         starve_cnt <= starve_cnt + CW'(1);
      end
   end
`else
   // Constant 0 for any legal STARVE_MAX: strict A priority.
   assign force_b = (STARVE_MAX < 0);
`endif

   always_comb begin
      grant_a = 1'b0;
      grant_b = 1'b0;
      if (slot_end && !bus.pause) begin
         if (bus.a_req && !force_b) begin
            grant_a = 1'b1;
         end else if (bus.b_req) begin
            grant_b = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         slot        <= 3'd4;
         state       <= IDLE;
         bus.a_ack   <= 1'b0;
         bus.b_ack   <= 1'b0;
         bus.a_rdata <= '0;
         bus.b_rdata <= '0;
         bus.sd_oe   <= 1'b0;
         bus.sd_we   <= 1'b0;
         bus.sd_addr <= '0;
         bus.sd_din  <= '0;
         bus.sd_ds   <= '0;
      end else begin
         slot      <= slot + 3'd1;
         bus.a_ack <= 1'b0;
         bus.b_ack <= 1'b0;

         // sd_ds[1] marks an odd (upper-lane) byte for the B access in flight.
         if (slot == RD_PT) begin
            if (state == BUSY_A) begin
               bus.a_rdata <= bus.sd_dout;
            end else if (state == BUSY_B && !bus.sd_we) begin
               bus.b_rdata <= bus.sd_ds[1] ? bus.sd_dout[15:8] : bus.sd_dout[7:0];
            end
         end

         if (slot_end) begin
            bus.a_ack <= (state == BUSY_A);
            bus.b_ack <= (state == BUSY_B);
            bus.sd_oe <= 1'b0;
            bus.sd_we <= 1'b0;
            state     <= IDLE;
            if (grant_a) begin
               state       <= BUSY_A;
               bus.sd_oe   <= 1'b1;
               bus.sd_addr <= bus.a_addr;
               bus.sd_ds   <= 2'b11;
            end else if (grant_b) begin
               state       <= BUSY_B;
               bus.sd_oe   <= ~bus.b_we;
               bus.sd_we   <= bus.b_we;
               bus.sd_addr <= bus.b_addr[24:1];
               bus.sd_din  <= {bus.b_wdata, bus.b_wdata};
               bus.sd_ds   <= bus.b_addr[0] ? 2'b10 : 2'b01;
            end
         end
      end
   end
endmodule

// File: tb/tb_sdram_arbiter.sv
// Bench for sdram_arbiter: directed vector table, hand-written corner sequences and a random phase
// checked every cycle against a frame-level model of the grant/ack rules.
module tb_sdram_arbiter;
   localparam int RD_SLOT    = 7;
   localparam int STARVE_MAX = 4;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   sdram_arbiter_if bus();

   sdram_arbiter #(.RD_SLOT(RD_SLOT), .STARVE_MAX(STARVE_MAX)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at time %0t", name, act, exp, $time);
      end
   endtask

   // Frame-level reference model: kind 0 = no access, 1 = port A, 2 = port B.
   typedef struct {
      int          kind;
      logic        we;
      logic [23:0] addr;
      logic [15:0] din;
      logic [1:0]  ds;
      logic        odd;
   } grant_t;

   grant_t      cur;
   int          m_slot;
   logic        m_a_ack, m_b_ack;
   logic [15:0] m_a_rdata;
   logic [7:0]  m_b_rdata;
`ifdef SDRAM_ARB_STARVE_EN
   int          m_starve;
`endif

   task automatic model_reset();
      cur.kind = 0; cur.we = 1'b0; cur.addr = '0; cur.din = '0; cur.ds = '0; cur.odd = 1'b0;
      m_slot = 4;
      m_a_ack = 1'b0; m_b_ack = 1'b0;
      m_a_rdata = '0; m_b_rdata = '0;
`ifdef SDRAM_ARB_STARVE_EN
      m_starve = 0;
`endif
   endtask

   task automatic decide(output grant_t g);
      logic b_first;
      g.kind = 0; g.we = 1'b0; g.addr = '0; g.din = '0; g.ds = '0; g.odd = 1'b0;
      b_first = 1'b0;
`ifdef SDRAM_ARB_STARVE_EN
      b_first = bus.b_req && (m_starve >= STARVE_MAX);
`endif
      if (!bus.pause) begin
         if (bus.a_req && !b_first) begin
            g.kind = 1;
            g.addr = bus.a_addr;
            g.ds   = 2'b11;
         end else if (bus.b_req) begin
            g.kind = 2;
            g.we   = bus.b_we;
            g.addr = 24'(bus.b_addr / 2);
            g.odd  = 1'(bus.b_addr % 2);
            g.ds   = g.odd ? 2'd2 : 2'd1;
            g.din  = 16'(bus.b_wdata) * 16'd257;
         end
      end
`ifdef SDRAM_ARB_STARVE_EN
      if (!bus.b_req || g.kind == 2) m_starve = 0;
      else if (g.kind == 1) m_starve++;
`endif
   endtask

   task automatic model_edge();
      grant_t g;
      m_a_ack = 1'b0;
      m_b_ack = 1'b0;
      if (m_slot == RD_SLOT) begin
         if (cur.kind == 1) m_a_rdata = bus.sd_dout;
         else if (cur.kind == 2 && !cur.we)
            m_b_rdata = cur.odd ? 8'(bus.sd_dout / 256) : 8'(bus.sd_dout % 256);
      end
      if (m_slot == 7) begin
         m_a_ack = (cur.kind == 1);
         m_b_ack = (cur.kind == 2);
         decide(g);
         cur = g;
      end
      m_slot = (m_slot + 1) % 8;
   endtask

   task automatic check_all();
      check("sd_sync", bus.sd_sync, m_slot < 4);
      check("sd_oe", bus.sd_oe, cur.kind != 0 && !cur.we);
      check("sd_we", bus.sd_we, cur.kind == 2 && cur.we);
      if (cur.kind != 0) begin
         check("sd_addr", bus.sd_addr, cur.addr);
         check("sd_ds", bus.sd_ds, cur.ds);
         if (cur.we) check("sd_din", bus.sd_din, cur.din);
      end
      check("a_ack", bus.a_ack, m_a_ack);
      check("b_ack", bus.b_ack, m_b_ack);
      check("a_rdata", bus.a_rdata, m_a_rdata);
      check("b_rdata", bus.b_rdata, m_b_rdata);
      check("sd_autorefresh", bus.sd_autorefresh, !bus.pause);
      check("sd_refresh", bus.sd_refresh, bus.pause);
   endtask

   task automatic step();
      @(posedge clk);
      if (!reset_n) model_reset();
      else model_edge();
      #1;
      check_all();
   endtask

   task automatic drop_all();
      bus.a_req = 1'b0;
      bus.b_req = 1'b0;
   endtask

   typedef struct {
      logic        a_req;
      logic [23:0] a_addr;
      logic        b_we;
      logic [24:0] b_addr;
      logic [7:0]  b_wdata;
      logic [15:0] dout;
      logic        e_oe;
      logic        e_we;
      logic [23:0] e_addr;
      logic [1:0]  e_ds;
      logic [15:0] e_din;
      logic [15:0] e_rdata;
   } vec_t;

   vec_t vecs[6];

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
      $fatal(1, "watchdog");
   end

   initial begin
      int n, lat, last, acks, kind;
      logic prev;

      vecs[0] = '{1'b1, 24'h000123, 1'b0, 25'h0000000, 8'h00, 16'hBEEF, 1'b1, 1'b0, 24'h000123, 2'b11, 16'h0000, 16'hBEEF};
      vecs[1] = '{1'b0, 24'h000000, 1'b1, 25'h0000011, 8'h5A, 16'h0000, 1'b0, 1'b1, 24'h000008, 2'b10, 16'h5A5A, 16'h0000};
      vecs[2] = '{1'b0, 24'h000000, 1'b0, 25'h0000010, 8'h00, 16'h1234, 1'b1, 1'b0, 24'h000008, 2'b01, 16'h0000, 16'h0034};
      vecs[3] = '{1'b0, 24'h000000, 1'b0, 25'h1FFFFFF, 8'h00, 16'hABCD, 1'b1, 1'b0, 24'hFFFFFF, 2'b10, 16'h0000, 16'h00AB};
      vecs[4] = '{1'b1, 24'hFFFFFF, 1'b0, 25'h0000000, 8'h00, 16'h0001, 1'b1, 1'b0, 24'hFFFFFF, 2'b11, 16'h0000, 16'h0001};
      vecs[5] = '{1'b0, 24'h000000, 1'b1, 25'h0000000, 8'hC3, 16'h0000, 1'b0, 1'b1, 24'h000000, 2'b01, 16'hC3C3, 16'h0000};

      bus.pause = 1'b0; bus.a_req = 1'b0; bus.a_addr = '0;
      bus.b_req = 1'b0; bus.b_we = 1'b0; bus.b_addr = '0; bus.b_wdata = '0; bus.sd_dout = '0;
      model_reset();

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst sd_sync", bus.sd_sync, 1'b0);
      check("rst sd_oe", bus.sd_oe, 1'b0);
      check("rst sd_we", bus.sd_we, 1'b0);
      check("rst sd_addr", bus.sd_addr, 24'h0);
      check("rst sd_din", bus.sd_din, 16'h0);
      check("rst sd_ds", bus.sd_ds, 2'b00);
      check("rst acks", {bus.a_ack, bus.b_ack}, 2'b00);
      check("rst rdata", {bus.a_rdata, bus.b_rdata}, 24'h0);
      check("rst autorefresh", bus.sd_autorefresh, 1'b1);
      reset_n = 1'b1;
      n = 0;
      while (!bus.sd_sync && n < 10) begin step(); n++; end
      check("first sync rise", n, 4);

      // Directed table: one request each, held until its ack
      for (int i = 0; i < 6; i++) begin
         bus.a_req   = vecs[i].a_req;
         bus.a_addr  = vecs[i].a_addr;
         bus.b_req   = !vecs[i].a_req;
         bus.b_we    = vecs[i].b_we;
         bus.b_addr  = vecs[i].b_addr;
         bus.b_wdata = vecs[i].b_wdata;
         bus.sd_dout = vecs[i].dout;
         n = 0;
         while (!(bus.sd_oe || bus.sd_we) && n < 20) begin step(); n++; end
         check("vec grant in time", n < 20, 1'b1);
         check("vec sd_oe", bus.sd_oe, vecs[i].e_oe);
         check("vec sd_we", bus.sd_we, vecs[i].e_we);
         check("vec sd_addr", bus.sd_addr, vecs[i].e_addr);
         check("vec sd_ds", bus.sd_ds, vecs[i].e_ds);
         if (vecs[i].e_we) check("vec sd_din", bus.sd_din, vecs[i].e_din);
         lat = 0;
         while (!(bus.a_ack || bus.b_ack) && lat < 20) begin step(); lat++; end
         check("vec ack latency", lat, 8);
         check("vec ack port", {bus.a_ack, bus.b_ack}, {vecs[i].a_req, !vecs[i].a_req});
         if (vecs[i].a_req) check("vec a_rdata", bus.a_rdata, vecs[i].e_rdata);
         else if (!vecs[i].b_we) check("vec b_rdata", bus.b_rdata, vecs[i].e_rdata);
         drop_all();
         repeat (10) step();
      end

      // Both ports held continuously for 10 frames
      n = 0;
      while (m_slot != 0 && n < 10) begin step(); n++; end
      bus.a_req = 1'b1; bus.a_addr = 24'h00AAAA;
      bus.b_req = 1'b1; bus.b_we = 1'b0; bus.b_addr = 25'h0000BBB;
      acks = 0;
      for (int f = 0; f < 10; f++) begin
         for (int s = 0; s < 8; s++) begin
            step();
            if (bus.b_ack) acks++;
         end
         kind = !bus.sd_oe ? 0 : (bus.sd_ds == 2'b11 ? 1 : 2);
`ifdef SDRAM_ARB_STARVE_EN
         check("starve grant pattern", kind, (f % 5 == 4) ? 2 : 1);
`else
         check("strict grant pattern", kind, 1);
`endif
      end
`ifdef SDRAM_ARB_STARVE_EN
      check("starve b_ack count", acks, 1);
`else
      check("strict b_ack count", acks, 0);
`endif
      drop_all();
      repeat (10) step();

      // Idle frames: sync period and refresh steering
      prev = bus.sd_sync; last = -1;
      for (int i = 0; i < 32; i++) begin
         step();
         if (bus.sd_sync && !prev) begin
            if (last >= 0) check("sync period", i - last, 8);
            last = i;
         end
         prev = bus.sd_sync;
      end
      check("idle oe/we", {bus.sd_oe, bus.sd_we}, 2'b00);
      check("idle autorefresh", bus.sd_autorefresh, 1'b1);

      // Pause blocks grants of a pending request
      bus.pause = 1'b1;
      bus.a_req = 1'b1; bus.a_addr = 24'h0F00D0;
      n = 0;
      for (int i = 0; i < 24; i++) begin step(); if (bus.sd_oe) n++; end
      check("paused grants", n, 0);
      check("paused refresh", bus.sd_refresh, 1'b1);
      bus.pause = 1'b0;
      n = 0;
      while (!bus.sd_oe && n < 20) begin step(); n++; end
      check("grant after pause", n <= 8, 1'b1);
      check("grant after pause addr", bus.sd_addr, 24'h0F00D0);
      n = 0;
      while (!bus.a_ack && n < 20) begin step(); n++; end
      check("ack after pause", n, 8);
      drop_all();
      repeat (10) step();

      // Asynchronous reset in slot 3 of an A frame
      bus.a_req = 1'b1; bus.a_addr = 24'h00C0DE;
      n = 0;
      while (!bus.sd_oe && n < 20) begin step(); n++; end
      check("pre-reset grant", bus.sd_oe, 1'b1);
      n = 0;
      while (m_slot != 3 && n < 10) begin step(); n++; end
      #2;
      reset_n = 1'b0;
      #1;
      model_reset();
      check("async rst sd_oe", bus.sd_oe, 1'b0);
      check("async rst sd_addr", bus.sd_addr, 24'h0);
      check("async rst sd_ds", bus.sd_ds, 2'b00);
      check("async rst sd_sync", bus.sd_sync, 1'b0);
      acks = 0;
      for (int i = 0; i < 3; i++) begin step(); if (bus.a_ack) acks++; end
      check("no ack across reset", acks, 0);
      reset_n = 1'b1;
      n = 0;
      while (!bus.sd_oe && n < 20) begin step(); n++; end
      check("regrant latency", n, 4);
      check("regrant addr", bus.sd_addr, 24'h00C0DE);
      n = 0;
      while (!bus.a_ack && n < 20) begin step(); n++; end
      check("regrant ack", n, 8);
      drop_all();
      repeat (10) step();

      // Randomized traffic, pause toggling and controller data
      for (int c = 0; c < 3000; c++) begin
         step();
         if (bus.a_req && bus.a_ack) begin
            bus.a_req = 1'b0;
         end else if (!bus.a_req && $urandom_range(0, 2) == 0) begin
            bus.a_req  = 1'b1;
            bus.a_addr = 24'($urandom);
         end
         if (bus.b_req && bus.b_ack) begin
            bus.b_req = 1'b0;
         end else if (!bus.b_req && $urandom_range(0, 2) == 0) begin
            bus.b_req   = 1'b1;
            bus.b_we    = 1'($urandom_range(0, 1));
            bus.b_addr  = 25'($urandom);
            bus.b_wdata = 8'($urandom);
         end
         if ($urandom_range(0, 40) == 0) bus.pause = ~bus.pause;
         bus.sd_dout = 16'($urandom);
      end
      bus.pause = 1'b0;
      drop_all();
      repeat (20) step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
